// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus: instruction-memory handshake, redirect input and IF/ID handshake.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  // Fetch sequencer side.
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  // Memory / pipeline side.
  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_entry,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Entry storage; contents are only observed while occupied, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues word fetches, buffers returned words,
// presents them to IF/ID and flushes on redirects.
// Optional: define FETCH_PERF_EN to add perf_fetched / perf_flushes counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_req;
  logic [XLEN-1:0] r_addr;

  fetch_entry_t    w_head;
  fetch_entry_t    w_entry;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_occ;
  logic            w_full;
  logic            w_empty;
  logic            w_redirect;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_ack;
  logic            w_push;
  logic            w_pop;
  logic            w_space_idle;
  logic            w_space_ack;

  assign w_redirect = bus.redirect_valid;
  assign w_redir_pc = word_align(bus.redirect_pc);
  assign w_next_pc  = r_fetch_pc + PC_STEP;
  assign w_ack      = bus.imem_ack & r_req;
  // Redirect kills the pending push and the consumer pop in the same cycle.
  assign w_push     = (r_state == REQ) & w_ack & ~w_redirect;
  assign w_pop      = ~w_empty & bus.if_ready & ~w_redirect;
  assign w_entry    = '{pc: r_fetch_pc, instr: bus.imem_rdata};

  // Occupancy after this cycle's push/pop; a new request must leave room for its reply.
  assign w_occ        = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_space_idle = ~w_full | w_pop;
  assign w_space_ack  = (w_occ < CNT_W'(BUF_DEPTH));

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_entry (w_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;
  assign bus.if_valid  = ~w_empty;
  assign bus.if_pc     = w_empty ? '0 : w_head.pc;
  assign bus.if_instr  = w_empty ? NOP_INSTR : w_head.instr;

  // Fetch FSM: request issue, ack handling, redirect and discard of stale replies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_addr     <= w_redir_pc;
          end else if (w_space_idle) begin
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (w_redirect) begin
            r_fetch_pc <= w_redir_pc;
            if (w_ack) begin
              r_req   <= 1'b0;
              r_addr  <= w_redir_pc;
              r_state <= IDLE;
            end else begin
              r_state <= DISCARD;
            end
          end else if (w_ack) begin
            r_fetch_pc <= w_next_pc;
            if (w_space_ack) begin
              r_addr <= w_next_pc;
            end else begin
              r_req   <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (w_redirect) r_fetch_pc <= w_redir_pc;
          if (w_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushes;

  // Popped-instruction and redirect counters; wrap on overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_pop)      r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_redirect) r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the PC logic and the instruction memory of the RISC-V pipeline. It issues word-aligned fetch requests over a req/ack handshake, buffers returned instructions in a small FIFO, presents them to the IF/ID register under a valid/ready handshake, and handles branch/jump redirects by flushing buffered and in-flight fetches. It replaces the bare PC register plus direct memory indexing, so the memory may take one or more cycles to respond.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- BUF_DEPTH, 2, fetch buffer entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch byte address, bits [1:0] always 0
- imem_ack  in  1  memory accepted request; imem_rdata valid in same cycle
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  taken branch/jump from EX, single-cycle pulse
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
- if_valid  out  1  if_pc/if_instr hold a valid instruction
- if_ready  in  1  IF/ID accepts (low = decode stall)
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction

## Operation

- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h00000013 (NOP), buffer empty, fetch_pc=RESET_PC, state IDLE.
- States:
  - IDLE: no request outstanding. If space exists, assert imem_req with imem_addr=fetch_pc and go to REQ.
  - REQ: imem_req high. req/addr hold stable until imem_ack. On ack without redirect: push {fetch_pc, imem_rdata}, fetch_pc+=4; issue next request the same cycle if space remains, otherwise go to IDLE.
  - DISCARD: redirect arrived while a request was unacknowledged. Hold old req/addr until ack, drop the data, then go to IDLE.
- Space rule: the next request may be issued iff (count − pop_this_cycle) < BUF_DEPTH, where pop = if_valid & if_ready.
- Redirect has priority over push, pop and issue:
  - buffer flushed; fetch_pc = {redirect_pc[31:2], 2'b00}.
  - An ack in the same cycle is dropped.
  - If REQ without ack: go to DISCARD. If IDLE, or REQ with ack: go to IDLE.
- Redirect while in DISCARD: update fetch_pc, stay in DISCARD.
- When empty, if_pc/if_instr show 0/NOP. if_valid never asserts in the cycle a redirect is sampled.
- fetch_pc wraps 32'hFFFF_FFFC → 0 silently.

## Timing

- First imem_req is asserted in the first clk cycle after reset deasserts.
- With a zero-wait memory (ack=req) and if_ready=1: one instruction per cycle. Fetch-to-if_valid latency is 1 cycle (registered buffer, no bypass).
- Redirect at edge N: the first instruction from the new target is presented at edge N+2 with a zero-wait memory.
- Simultaneous push and pop on a full buffer is legal; count is unchanged.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously); an outstanding ack is ignored.

## Configuration

- FETCH_PERF_EN defined:
  - Adds outputs perf_fetched (32, count of instructions popped) and perf_flushes (32, count of redirects).
  - Both reset to 0 and wrap on overflow.
- FETCH_PERF_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure

- Package fetch_pkg:
  - NOP_INSTR = 32'h00000013
  - state enum {IDLE, REQ, DISCARD}
  - buffer entry struct {pc[31:0], instr[31:0]}
- Sub-module fetch_buf: synchronous FIFO of entries with push, pop, flush, count, full/empty. Flush takes priority over push in the same cycle.
- The FSM and PC update stay in fetch_ctrl.

## Test plan

- Reset, zero-wait memory, if_ready=1 → if_pc = 0, 4, 8, 12 on consecutive cycles; first if_valid 2 cycles after reset release.
- if_ready=0 for 5 cycles → buffer fills to 2, imem_req drops; on release, PCs continue 8, 12 with no gap or duplicate.
- Redirect_pc=0x20 in the same cycle as the ack for 0x10 → 0x10 is never presented; next if_pc=0x20, buffer flushed.
- Memory with 3-cycle ack latency; redirect_pc=0x40 one cycle after a request to 0x8 → addr 0x8 held until ack, its data dropped, next request addr=0x40.
- Redirect_pc=0x23 → imem_addr=0x20; then fetch from 0xFFFF_FFFC → next address 0x0.
- With FETCH_PERF_EN: 10 pops and 2 redirects → perf_fetched=10, perf_flushes=2; both return to 0 on reset.
